// File: rtl/seg_scan_pkg.sv
// Shared types and glyph constants for the 6-digit multiplexed 7-segment scanner.
// Glyphs are active-high in {g,f,e,d,c,b,a} order.
package seg_scan_pkg;

    localparam int NUM_DIG = 6;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

endpackage

// File: rtl/seg_bcd_dec.sv
// Combinational 4-bit code to 7-segment glyph decoder (0-9 decimal, 10-15 as A,b,C,d,E,F).
module seg_bcd_dec
    import seg_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_0;
        case (code)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan scheduler with blanking guard and frame-synchronous double buffer.
// Optional macro SEG_LZB_EN enables leading-zero blanking on digits 1..5.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SLOT_HZ   = 1000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_digits,
    input  logic [5:0]  i_dp,
    input  logic        i_load,
    output logic [6:0]  o_seg,
    output logic        o_seg_dp,
    output logic [5:0]  o_seg_enb,
    output logic        o_frame_done
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);

    generate
        if ((GUARD_CYC < 1) || (GUARD_CYC >= DIV)) begin : g_bad_guard
            $error("seg_scan_ctrl: GUARD_CYC must satisfy 1 <= GUARD_CYC < CLK_HZ/SLOT_HZ");
        end
    endgenerate

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         idx_reg;
    logic [23:0]        pend_dig_reg;
    logic [5:0]         pend_dp_reg;
    logic [23:0]        act_dig_reg;
    logic [5:0]         act_dp_reg;
    logic [6:0]         seg_reg;
    logic               dp_reg;
    logic [5:0]         enb_reg;
    logic               frame_done_reg;

    logic [3:0]         act_code [NUM_DIG];
    logic [NUM_DIG-1:0] enb_onehot;
    logic [3:0]         cur_code;
    logic [6:0]         dec_seg;
    logic [6:0]         show_seg;
    logic               lzb_blank;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign act_code[gi]   = act_dig_reg[gi*4 +: 4];
            assign enb_onehot[gi] = (idx_reg == 3'(gi));
        end
    endgenerate

    assign cur_code = act_code[idx_reg];

    seg_bcd_dec u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

`ifdef SEG_LZB_EN
    // Blank digit n>0 when it and every digit above it are zero.
    assign lzb_blank = (idx_reg != 3'd0) && ((act_dig_reg >> {idx_reg, 2'b00}) == 24'd0);
`else
    assign lzb_blank = 1'b0;
`endif

    assign show_seg = lzb_blank ? 7'd0 : dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= BLANK;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pend_dig_reg   <= '0;
            pend_dp_reg    <= '0;
            act_dig_reg    <= '0;
            act_dp_reg     <= '0;
            seg_reg        <= '0;
            dp_reg         <= 1'b0;
            enb_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (i_load) begin
                pend_dig_reg <= i_digits;
                pend_dp_reg  <= i_dp;
            end
            case (state_reg)
                BLANK: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == GUARD_LAST) begin
                        state_reg <= SHOW;
                        enb_reg   <= enb_onehot;
                        seg_reg   <= show_seg;
                        dp_reg    <= act_dp_reg[idx_reg];
                    end
                end
                SHOW: begin
                    if (cnt_reg == DIV_LAST) begin
                        state_reg <= BLANK;
                        cnt_reg   <= '0;
                        enb_reg   <= '0;
                        seg_reg   <= '0;
                        dp_reg    <= 1'b0;
                        if (idx_reg == 3'(NUM_DIG - 1)) begin
                            idx_reg        <= '0;
                            frame_done_reg <= 1'b1;
                            // A load coinciding with the swap bypasses pending so it is not lost a frame.
                            act_dig_reg    <= i_load ? i_digits : pend_dig_reg;
                            act_dp_reg     <= i_load ? i_dp     : pend_dp_reg;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= BLANK;
            endcase
        end
    end

    assign o_seg        = seg_reg;
    assign o_seg_dp     = dp_reg;
    assign o_seg_enb    = enb_reg;
    assign o_frame_done = frame_done_reg;

endmodule
